// File: rtl/uart_rx_pkg.sv
// Shared types and word-field constants for the uart_rx_word receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitHigh
    } rx_state_e;

    localparam int unsigned SEQ_LSB  = 16;
    localparam int unsigned PERR_BIT = 9;
    localparam int unsigned FERR_BIT = 8;
    localparam int unsigned DATA_W   = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, held in phase by restart.
module uart_baud_tick #(
    parameter int unsigned DIV = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_d, cnt_q;

    always_comb begin
        tick  = 1'b0;
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_word.sv
// UART receiver packing each character, its error flags and a sequence count into a PIO word.
// Parity support is compiled in with UART_RX_PARITY_EN.
module uart_rx_word
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic [31:0] pio_word,
    output logic        rx_valid
);

    localparam int unsigned DIV_RAW = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned TW      = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);

    logic rx_meta_q, rx_s_q, rx_prev_q;
    logic tick, restart, bit_end;

    rx_state_e         state_d, state_q;
    logic [TW-1:0]     tick_cnt_d, tick_cnt_q;
    logic [2:0]        bit_cnt_d, bit_cnt_q;
    logic [DATA_W-1:0] shift_d, shift_q;
    logic              perr_d, perr_q;
    logic [7:0]        seq_d, seq_q;
    logic [31:0]       word_d, word_q;
    logic              valid_d, valid_q;

`ifndef UART_RX_PARITY_EN
    logic unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
`endif

    // Hold the divider in reset while waiting for a start edge so ticks are frame-aligned.
    assign restart = (state_q == StIdle) || (state_q == StWaitHigh);
    assign bit_end = tick && (tick_cnt_q == BIT_LAST);

    uart_baud_tick #(
        .DIV(DIV)
    ) u_baud_tick (
        .clk    (clk),
        .reset  (reset),
        .restart(restart),
        .tick   (tick)
    );

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        seq_d      = seq_q;
        word_d     = word_q;
        valid_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_prev_q && !rx_s_q) begin
                    state_d    = StStart;
                    tick_cnt_d = '0;
                end
            end
            StStart: begin
                if (tick) begin
                    if (tick_cnt_q == HALF_LAST) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        perr_d     = 1'b0;
                        state_d    = rx_s_q ? StIdle : StData;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (bit_end) begin
                    tick_cnt_d = '0;
                    shift_d    = {rx_s_q, shift_q[DATA_W-1:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    tick_cnt_d = '0;
                    perr_d     = (^shift_q) ^ rx_s_q ^ (PARITY_ODD != 0);
                    state_d    = StStop;
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    seq_d                      = seq_q + 8'd1;
                    word_d                     = '0;
                    word_d[SEQ_LSB +: 8]       = seq_q + 8'd1;
                    word_d[PERR_BIT]           = perr_q;
                    word_d[FERR_BIT]           = ~rx_s_q;
                    word_d[DATA_W-1:0]         = shift_q;
                    valid_d                    = 1'b1;
                    // A zero character with a low stop bit is a break; wait for the line to recover.
                    state_d = (!rx_s_q && shift_q == '0) ? StWaitHigh : StIdle;
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            StWaitHigh: begin
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            seq_q      <= '0;
            word_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            rx_prev_q  <= rx_s_q;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            seq_q      <= seq_d;
            word_q     <= word_d;
            valid_q    <= valid_d;
        end
    end

    assign pio_word = word_q;
    assign rx_valid = valid_q;

endmodule

// File: doc/uart_rx_word.md
# uart_rx_word

Serial UART receiver that recovers 8-bit characters from the asynchronous `rx` line and packs each character with its status and a rolling sequence count into a 32-bit word. The block sits directly upstream of the NIOS2 receive PIO and drives its 32-bit `in_port`. Software polls the PIO and detects new characters by a change in the sequence field, so no acknowledge path back from the processor is needed.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 115200: line bit rate.
- `OVERSAMPLE`, default 16: ticks per bit. Must be even and ≥ 8.
- `PARITY_ODD`, default 0: parity sense, 1 = odd. Used only when the parity feature is compiled in.
- `clk`  in  1: system clock; all state is on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `rx`  in  1: raw serial input, idle high, asynchronous to `clk`.
- `pio_word`  out  32: registered status word, wired to the PIO `in_port`.
- `rx_valid`  out  1: one-cycle pulse on the cycle `pio_word` updates.

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1). The FSM sees only the synchronized signal `rx_s`.
- Tick divider: `DIV = max(1, (CLK_HZ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE))`, integer arithmetic. With defaults, DIV = 27. `tick` asserts for one `clk` every DIV cycles.
  - The divider and the in-bit tick counter restart on leaving IDLE.
- Frame format: 1 start bit, 8 data bits LSB first, [parity], 1 stop bit.
- FSM states and transitions:
  - IDLE: a high→low transition on `rx_s` moves to START.
  - START: after OVERSAMPLE/2 ticks, sample `rx_s`. If 1, it is a false start; return to IDLE with no output. If 0, go to DATA.
  - DATA: sample every OVERSAMPLE ticks into a shift register. After 8 samples go to PARITY (feature on) or STOP.
  - PARITY: sample one bit and compare it with the computed parity of the data; go to STOP.
  - STOP: sample one bit.
    - Sample 1: publish the word, go to IDLE.
    - Sample 0: publish the word with frame error set. If data = 0x00 (break), go to WAIT_HIGH; otherwise go to IDLE.
  - WAIT_HIGH: stay until `rx_s` = 1, then go to IDLE. No words are published during a break.
- `pio_word` layout:
  - [31:24] = 0
  - [23:16] = seq
  - [15:10] = 0
  - [9] = parity error
  - [8] = frame error
  - [7:0] = data
- seq is an 8-bit count that increments on every publish and wraps from 255 to 0.
- Error bits describe the current character only; they are not sticky.

## Timing
- Reset values: `pio_word` = 0x0000_0000, `rx_valid` = 0, seq = 0, FSM = IDLE.
- Latency from an `rx` edge to `rx_s`: 2 `clk`.
- `pio_word` and `rx_valid` update 1 `clk` after the tick on which the stop bit is sampled. Between publishes, `pio_word` holds its value.
- Back-to-back frames: the next start edge is accepted from IDLE. IDLE is re-entered immediately after the stop-bit sample, which is mid-stop-bit, so a start bit directly following the stop bit is caught.
- Reset asserted mid-frame aborts the frame and returns every output to its reset value. The first falling edge after reset release starts a clean frame.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The frame carries a parity bit and the PARITY state exists.
  - Bit [9] reports a mismatch against even parity, or odd parity when `PARITY_ODD` = 1.
- Not defined:
  - The frame is 8N1 and the PARITY state is absent.
  - Bit [9] is constant 0.
  - `PARITY_ODD` is ignored.

## Structure
- Package `uart_rx_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - word field constants: `SEQ_LSB` = 16, `PERR_BIT` = 9, `FERR_BIT` = 8, `DATA_W` = 8.
- Sub-module `uart_baud_tick` contains the DIV counter; its inputs are `clk`, `reset` and a restart strobe, and its output is `tick`.
- The synchronizer, FSM, shift register and word register stay in `uart_rx_word`.

## Test plan
- Send 0xA5 at 115200 8N1 after reset → `pio_word` = 0x0001_00A5 and exactly one `rx_valid` pulse.
- Send 0x00 then 0xFF back-to-back with no idle gap → two pulses; final `pio_word` = 0x0002_00FF.
- Drive `rx` low for 4 oversample ticks, then high → no `rx_valid` pulse and `pio_word` unchanged (false start).
- Send 0x3C with the stop bit forced to 0 → `pio_word` = 0x0001_013C, then next frame 0x41 → 0x0002_0041.
- Hold `rx` low for 20 bit times, then release → exactly one word, 0x0001_0100; the next valid byte gets seq 2.
- With `UART_RX_PARITY_EN` and `PARITY_ODD` = 0, send 0x01 with parity bit 0 → bit 9 set. Then assert `reset` mid-frame → `pio_word` = 0. Send 257 frames → seq wraps to 0x01.
